// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding, invalid-address constant and a
// per-port select helper reused by the FSM, sync and register blocks.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Picks the bit of a per-port vector for a 2-bit address; the invalid address selects nothing.
    function automatic logic port_sel(input logic [2:0] bits, input logic [1:0] addr);
        case (addr)
            2'd0:    return bits[0];
            2'd1:    return bits[1];
            2'd2:    return bits[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity loading
// and FIFO-full stalls. Define ROUTER_FSM_PKT_CNT_EN to add the pkt_count output.
module router_fsm
    import router_pkg::*;
#(
    parameter int PKT_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [1:0]           data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic                 fifo_empty_0,
    input  logic                 fifo_empty_1,
    input  logic                 fifo_empty_2,
    input  logic                 soft_reset_0,
    input  logic                 soft_reset_1,
    input  logic                 soft_reset_2,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0] pkt_count
`endif
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_reg;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       hdr_ok;
    logic       soft_hit;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok     = pkt_valid && (data_in != ADDR_INVALID);
    // Only the timeout of the port this packet targets may abort it.
    assign soft_hit   = port_sel(soft_reset, addr_reg);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'd0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_ok) begin
                addr_reg <= data_in;
            end
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    next_state = port_sel(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (port_sel(fifo_empty, addr_reg)) next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        if (soft_hit) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY);
        busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    // Counts packets that complete parity checking; soft-reset aborts never reach here.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (state == CHECK_PARITY_ERROR && next_state == DECODE_ADDRESS && !soft_hit) begin
            pkt_count <= pkt_count + PKT_CNT_W'(1);
        end
    end
`else
    logic [PKT_CNT_W-1:0] unused_pkt_cnt_w;
    assign unused_pkt_cnt_w = '0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: each step pushes the expected Moore
// output vector, advances one clock and pops/compares it against the DUT.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1;
    logic       fifo_empty_1 = 1'b1;
    logic       fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0;
    logic       soft_reset_1 = 1'b0;
    logic       soft_reset_2 = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [7:0] pkt_count;
`endif

    router_fsm #(.PKT_CNT_W(8)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
`ifdef ROUTER_FSM_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clock = ~clock;

    // Expected outputs {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} per state.
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0100;
    localparam logic [7:0] E_LAF = 8'b0001_0101;
    localparam logic [7:0] E_FUL = 8'b0000_1001;
    localparam logic [7:0] E_LP  = 8'b0000_0101;
    localparam logic [7:0] E_CPE = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests_run = 0;
    int  tests_failed = 0;
    int  exp_count = 0;

    function automatic logic [7:0] observed();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    task automatic step(input string tag, input logic [7:0] exp);
        sb_t item;
        sb_t got;
        logic [7:0] obs;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        obs = observed();
        tests_run++;
        assert (obs === got.exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", got.tag, obs, got.exp);
        end
    endtask

    task automatic check_count(input string tag);
`ifdef ROUTER_FSM_PKT_CNT_EN
        logic [7:0] want;
        want = exp_count[7:0];
        tests_run++;
        assert (pkt_count === want) else begin
            tests_failed++;
            $error("FAIL %s: observed pkt_count %0d expected %0d", tag, pkt_count, want);
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic normal_packet(input string tag);
        pkt_valid = 1'b1; data_in = 2'd1;
        step({tag, "_lfd"}, E_LFD);
        step({tag, "_ld"}, E_LD);
        pkt_valid = 1'b0;
        step({tag, "_lp"}, E_LP);
        step({tag, "_cpe"}, E_CPE);
        step({tag, "_da"}, E_DA);
        exp_count++;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        reset = 1'b1;
        step("reset", E_DA);
        reset = 1'b0;
        check_count("reset_cnt");

        // Normal packet to port 1, pkt_valid high for four cycles
        pkt_valid = 1'b1; data_in = 2'd1;
        step("norm_lfd", E_LFD);
        step("norm_ld1", E_LD);
        step("norm_ld2", E_LD);
        step("norm_ld3", E_LD);
        pkt_valid = 1'b0;
        step("norm_lp", E_LP);
        step("norm_cpe", E_CPE);
        step("norm_da", E_DA);
        exp_count++;
        check_count("norm_cnt");

        // Port 2 not empty: wait five cycles, then load once it drains
        fifo_empty_2 = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd2;
        step("wte_1", E_WTE);
        pkt_valid = 1'b0; data_in = 2'd0;
        for (int i = 0; i < 4; i++) step("wte_n", E_WTE);
        fifo_empty_2 = 1'b1;
        step("wte_lfd", E_LFD);
        step("wte_ld", E_LD);
        step("wte_lp", E_LP);
        step("wte_cpe", E_CPE);
        step("wte_da", E_DA);
        exp_count++;

        // FIFO full for three cycles mid-payload
        pkt_valid = 1'b1; data_in = 2'd0;
        step("full_lfd", E_LFD);
        step("full_ld", E_LD);
        fifo_full = 1'b1;
        step("full_1", E_FUL);
        step("full_2", E_FUL);
        step("full_3", E_FUL);
        fifo_full = 1'b0;
        step("full_laf", E_LAF);
        step("full_back_ld", E_LD);
        pkt_valid = 1'b0;
        step("full_lp", E_LP);
        // Parity check sees a full FIFO: stall again, then finish via low_pkt_valid
        fifo_full = 1'b1;
        step("cpe_full_cpe", E_CPE);
        step("cpe_full", E_FUL);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        step("lpv_laf", E_LAF);
        step("lpv_lp", E_LP);
        low_pkt_valid = 1'b0;
        step("lpv_cpe", E_CPE);
        step("lpv_da", E_DA);
        exp_count++;
        check_count("full_cnt");

        // parity_done in LOAD_AFTER_FULL returns straight to decode without counting
        pkt_valid = 1'b1; data_in = 2'd2;
        step("pd_lfd", E_LFD);
        step("pd_ld", E_LD);
        fifo_full = 1'b1;
        step("pd_full", E_FUL);
        fifo_full = 1'b0; parity_done = 1'b1; pkt_valid = 1'b0;
        step("pd_laf", E_LAF);
        step("pd_da", E_DA);
        parity_done = 1'b0;
        check_count("pd_cnt");

        // Soft reset on a different port is ignored; the matching one aborts
        fifo_empty_0 = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd0;
        step("sr_wte", E_WTE);
        pkt_valid = 1'b0;
        soft_reset_1 = 1'b1;
        step("sr_other", E_WTE);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step("sr_match", E_DA);
        soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
        check_count("sr_cnt");

        // Invalid address 2'b11 never leaves decode
        pkt_valid = 1'b1; data_in = 2'b11;
        step("inv_1", E_DA);
        step("inv_2", E_DA);
        pkt_valid = 1'b0;

        // Reset mid-packet wins over everything
        pkt_valid = 1'b1; data_in = 2'd1;
        step("mid_lfd", E_LFD);
        step("mid_ld", E_LD);
        reset = 1'b1;
        step("mid_reset", E_DA);
        reset = 1'b0; pkt_valid = 1'b0;
        exp_count = 0;
        check_count("mid_reset_cnt");

`ifdef ROUTER_FSM_PKT_CNT_EN
        // 256 completed packets wrap an 8-bit counter back to zero
        for (int i = 0; i < 256; i++) normal_packet("wrap");
        check_count("wrap_cnt");
`else
        normal_packet("extra");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter PKT_CNT_W, default 8: width of packet-done counter (used only with ROUTER_FSM_PKT_CNT_EN).
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have pkt_valid, input, 1: header/payload byte valid from source.
REQ-005 SHALL have data_in, input, 2: destination address bits of header byte.
REQ-006 SHALL have parity_done, input, 1: register block has loaded parity.
REQ-007 SHALL have low_pkt_valid, input, 1: pkt_valid fell while FIFO was full.
REQ-008 SHALL have fifo_full, input, 1: selected FIFO full (from sync).
REQ-009 SHALL have fifo_empty_0/1/2, input, 1 each: per-port FIFO empty.
REQ-010 SHALL have soft_reset_0/1/2, input, 1 each: per-port read-timeout reset (from sync).
REQ-011 SHALL have detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy, output, 1 each.

Function
REQ-012 SHALL implement 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-013 SHALL latch data_in into addr_reg in DECODE_ADDRESS when pkt_valid=1 and data_in!=2'b11.
REQ-014 DECODE_ADDRESS: pkt_valid && data_in!=3 && fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid && data_in!=3 && !fifo_empty[data_in] -> WAIT_TILL_EMPTY; else (incl. data_in=3) stay.
REQ-015 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
REQ-016 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
REQ-017 FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
REQ-018 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-019 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-020 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-021 WAIT_TILL_EMPTY: fifo_empty[addr_reg] -> LOAD_FIRST_DATA; else stay.
REQ-022 soft_reset_N with N==addr_reg SHALL force DECODE_ADDRESS next cycle from any state, overriding REQ-014..021; soft_reset on other ports SHALL be ignored.
REQ-023 Outputs SHALL be Moore decodes of state register (zero latency from state): detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, full_state=FIFO_FULL_STATE, laf_state=LOAD_AFTER_FULL, rst_int_reg=CHECK_PARITY_ERROR.
REQ-024 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
REQ-025 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.

Reset
REQ-026 reset=1 SHALL force DECODE_ADDRESS and addr_reg=0 at next edge, with priority over soft_reset and all transitions, including mid-packet.
REQ-027 After reset outputs SHALL be detect_add=1, all other outputs 0 (pkt_count=0 if enabled).

Configuration
REQ-028 With ROUTER_FSM_PKT_CNT_EN defined, SHALL add output pkt_count[PKT_CNT_W-1:0], incremented on each CHECK_PARITY_ERROR->DECODE_ADDRESS transition, wrapping to 0 after all-ones; soft-reset aborts SHALL NOT count.
REQ-029 Without ROUTER_FSM_PKT_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package router_pkg SHALL hold state encoding typedef and constant ADDR_INVALID=2'b11; sync and register blocks reuse it.
REQ-031 No sub-module; single flat module with state register, addr_reg, next-state and output decode.

Verification
REQ-032 Reset: reset=1 one cycle -> detect_add=1, busy=0, write_enb_reg=0.
REQ-033 Normal packet addr 1, fifo_empty_1=1, pkt_valid high 4 cycles -> states DECODE, LFD, LOAD_DATA x3, LOAD_PARITY, CHECK_PARITY, DECODE; write_enb_reg=1 for 4 cycles.
REQ-034 Addr 2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 5 cycles, then LFD after fifo_empty_2=1.
REQ-035 fifo_full=1 mid LOAD_DATA for 3 cycles -> full_state=1 3 cycles, then laf_state=1 one cycle, back to LOAD_DATA.
REQ-036 In WAIT_TILL_EMPTY addr 0: soft_reset_1=1 -> no change; soft_reset_0=1 -> detect_add=1 next cycle.
REQ-037 data_in=2'b11 with pkt_valid=1 -> remains DECODE_ADDRESS, busy=0; with macro, pkt_count after 256 packets (W=8) reads 0.
